mem_access_ctrl: RTL

//  Sequencer between the CPU datapath (MAR/MDR side) and the 512x32 RAM.
//  - Accepts one load/store request per valid/ready handshake.
//  - Drives the RAM read/write strobes, address and write data from registers, so they are stable across the RAM's negedge sample.
//  - Captures read data into a response register and returns a one-cycle response pulse.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_byte_merge.sv | 27 ++
 rtl/mem_access_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Package: mem_ctrl_pkg
// Shared types and default constants for the memory access controller.
//   state_t     controller FSM states (also exported on the debug port)
//   ADDR_W_DEF  default RAM address width
//   DATA_W_DEF  default data word width (multiple of 8)
//   BYTES       byte lanes in a default-width word
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int BYTES      = DATA_W_DEF / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Module: mem_byte_merge
// Combinational byte-lane merge used by the read-modify-write path.
// Present only when MEM_CTRL_BYTE_WRITE_EN is defined; the controller does
// not instantiate it otherwise.
// Ports:
//   old_word  in   DATA_W     word read back from the RAM
//   new_word  in   DATA_W     store data from the request
//   be        in   DATA_W/8   byte enables, 1 = take the new byte
//   merged    out  DATA_W     per-byte selection of new/old
`ifdef MEM_CTRL_BYTE_WRITE_EN
module mem_byte_merge
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);

    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Module: mem_access_ctrl
// Sequencer between the CPU datapath and a 512x32 RAM. One load/store is
// accepted per handshake; RAM strobes, address and write data come straight
// from registers so they are stable when the RAM samples on the negedge.
// Load data is captured into rsp_rdata and a one-cycle rsp_valid is returned.
// Optional feature: MEM_CTRL_BYTE_WRITE_EN enables byte-enabled stores
// (full write, no-op, or read-modify-write via mem_byte_merge).
// Ports:
//   clock, clear_n          clock and synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_write/addr/wdata/be request fields (be used only with the macro)
//   rsp_valid/err/rdata     response pulse, range error flag, load data
//   mem_read/write/addr/wdata, mem_rdata   RAM interface
//   dbg_state               current FSM state
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = 512
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output state_t              dbg_state
);

    state_t              state, state_n;
    logic                rd_n, wr_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n, rdata_n;
    logic                accept, addr_bad;

`ifdef MEM_CTRL_BYTE_WRITE_EN
    logic [DATA_W/8-1:0] be_q, be_n;
    logic [DATA_W-1:0]   merged;

    // mem_wdata still holds the request data during RMW_RD, so it is the
    // "new" side of the merge; mem_rdata carries the old word.
    mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (mem_rdata),
        .new_word (mem_wdata),
        .be       (be_q),
        .merged   (merged)
    );
`else
    logic unused_be;
    assign unused_be = ^req_be;
`endif

    // Handshake: a request transfers on a posedge where req_valid && req_ready.
    // req_ready depends only on state and clear_n (never on req_valid); the
    // requester holds its fields stable while req_valid is high and unaccepted.
    assign req_ready = clear_n && (state == IDLE || state == RESP);
    assign accept    = req_valid && req_ready;
    assign addr_bad  = (32'(req_addr) >= 32'(MEM_DEPTH));
    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        rdata_n   = rsp_rdata;
        rsp_err_n = 1'b0;
`ifdef MEM_CTRL_BYTE_WRITE_EN
        be_n      = be_q;
`endif
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    if (addr_bad) begin
                        // Out-of-range: no RAM cycle, answer immediately.
                        state_n   = RESP;
                        rsp_err_n = 1'b1;
                    end else if (!req_write) begin
                        state_n = ACCESS;
                        rd_n    = 1'b1;
                    end else begin
`ifdef MEM_CTRL_BYTE_WRITE_EN
                        if (&req_be) begin
                            state_n = ACCESS;
                            wr_n    = 1'b1;
                        end else if (req_be == '0) begin
                            state_n = RESP;
                        end else begin
                            state_n = RMW_RD;
                            rd_n    = 1'b1;
                            be_n    = req_be;
                        end
`else
                        state_n = ACCESS;
                        wr_n    = 1'b1;
`endif
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ACCESS: begin
                state_n = RESP;
                // Only loads update the response data.
                if (mem_read) begin
                    rdata_n = mem_rdata;
                end
            end
            RMW_RD: begin
`ifdef MEM_CTRL_BYTE_WRITE_EN
                state_n = RMW_WR;
                wr_n    = 1'b1;
                wdata_n = merged;
`else
                state_n = IDLE;
`endif
            end
            RMW_WR: state_n = RESP;
            default: state_n = IDLE;
        endcase
        rsp_valid_n = (state_n == RESP);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_CTRL_BYTE_WRITE_EN
            be_q      <= '0;
`endif
        end else begin
            state     <= state_n;
            mem_read  <= rd_n;
            mem_write <= wr_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rdata_n;
`ifdef MEM_CTRL_BYTE_WRITE_EN
            be_q      <= be_n;
`endif
        end
    end

endmodule
